cdb_arbiter: RTL
================

# cdb_arbiter

Shares the single ALU-side common data bus between several execution-unit result producers (ALU, branch/JALR unit, auxiliary unit). Each source pushes `{rob_id, value}` results into a small per-source queue. A round-robin arbiter grants one queued result per cycle onto a registered CDB port, which the reorder buffer consumes as `_cdb_ready/_cdb_rob_id/_cdb_value`. A flush from the reorder buffer discards all in-flight results.

## Interface
**Parameters**
- `NUM_SRC`, default 3: number of result sources (2..8).
- `DEPTH`, default 2: entries per source queue (power of two, ≥2).
- `ROB_ID_W`, default 5: ROB index width.
- `DATA_W`, default 32: result width.

**Ports**
- `clk_in`, in, 1: system clock.
- `rst_in`, in, 1: reset, **synchronous, active-low**.
- `rdy_in`, in, 1: global ready; freeze when low.
- `_clear`, in, 1: flush from the ROB.
- `_src_valid`, in, NUM_SRC: result offered, one bit per source.
- `_src_ready`, out, NUM_SRC: source queue can accept.
- `_src_rob_id`, in, NUM_SRC*ROB_ID_W: packed ROB ids; source i at bits [i*ROB_ID_W +: ROB_ID_W].
- `_src_value`, in, NUM_SRC*DATA_W: packed values, same packing.
- `_cdb_ready`, out, 1: broadcast valid, registered.
- `_cdb_rob_id`, out, ROB_ID_W: broadcast ROB id, registered.
- `_cdb_value`, out, DATA_W: broadcast value, registered.
- `_cdb_src`, out, 3: index of the granted source, registered (debug).

## Operation
- **Push.** Source i pushes on a rising edge when `_src_valid[i] && _src_ready[i]`.
  - `_src_ready[i] = rdy_in && !_clear && count[i] != DEPTH`.
  - Ready does not depend on a same-cycle pop; there is no combinational valid→ready path.
- **Queues.** Each queue is a FIFO with `rd_ptr`, `wr_ptr` and `count` of width log2(DEPTH)+1. Pointers wrap modulo DEPTH.
- **Candidates.** Source i is a candidate when `count[i] != 0`.
- **Arbitration.**
  - Round-robin search starts at `(last_grant + 1) mod NUM_SRC`; the first candidate found wins.
  - On a grant: pop that queue, update `last_grant`, and load the output registers with the head entry and `_cdb_ready <= 1`.
  - With no candidate: `_cdb_ready <= 0`; `_cdb_rob_id`, `_cdb_value` and `_cdb_src` hold their values.
- **Simultaneous push and pop** on one queue: `count` is unchanged and both pointers advance. A push into an empty queue is not eligible in the same cycle.
- **Flush.** `_clear` high at an edge:
  - all counts and pointers go to 0;
  - `_cdb_ready <= 0`;
  - no push and no grant occur;
  - `last_grant` is unchanged.
- **Freeze.** `rdy_in` low:
  - no push, pop or pointer change;
  - `_cdb_ready <= 0`, so each result is broadcast exactly one cycle;
  - the held entry stays queued and is granted after `rdy_in` returns.
- **Priority when both are active:** reset > `_clear` > `!rdy_in` > normal.

## Timing
- **Reset values.** Reset is sampled at the edge when `rst_in == 0`:
  - `_cdb_ready = 0`, `_cdb_rob_id = 0`, `_cdb_value = 0`, `_cdb_src = 0`;
  - all queues empty, so `_src_ready` = all ones once `rdy_in` is high;
  - `last_grant = NUM_SRC-1`, so source 0 wins first.
- **Latency.** A push at edge t is granted at edge t+1 at the earliest; `_cdb_ready` is high during cycle t+1..t+2.
- **Throughput.** One broadcast per cycle in aggregate.
- **Fairness.** A continuously non-empty source waits at most NUM_SRC-1 grants.
- **Reset mid-operation.** Queued results are lost and no broadcast is emitted on the following cycle.

## Configuration
- Macro: `CDB_ARB_STATS_EN`.
- **Defined:** adds output ports
  - `_stat_grant_cnt` (NUM_SRC*32): per-source grant counters;
  - `_stat_conflict_cnt` (32): counts non-frozen cycles with ≥2 candidates.
  - Counters are zeroed by reset only (not by `_clear`), wrap at 2^32, and do not count while `rdy_in` is low.
- **Undefined:** the ports and counters are absent; arbitration behaviour is identical.

## Structure
- Shared package/include `cpu_pkg`: `ROB_ID_W`, `DATA_W`, CDB result struct/field widths, and the reset-polarity constant.
- One sub-module: `cdb_src_fifo` (parameterized DEPTH/width queue with `count`, `push`, `pop` and `flush`), instantiated NUM_SRC times via generate.
- The round-robin select stays in `cdb_arbiter`.

## Test plan
- **Reset, then single result.** Reset, then src1 pushes {rob 3, 0x1234} at edge 0 → `_cdb_ready=1`, rob 3, value 0x1234, `_cdb_src=1` during cycle 1→2 only.
- **Round-robin.** All three sources push one result in the same cycle, after reset → grant order src0, src1, src2 on three consecutive cycles.
- **Backpressure.** src0 pushes 3 back-to-back while src1 and src2 are busy → `_src_ready[0]` low after 2 entries; src0 results are broadcast in FIFO order; none are lost.
- **Flush.** Two queued results, then `_clear` high for one cycle → `_cdb_ready` stays 0 and queues are empty. A push after the clear is broadcast with normal latency.
- **Freeze.** `rdy_in` low for 3 cycles with a queued entry → no broadcast and `_src_ready` low. The entry is broadcast once, one cycle after `rdy_in` rises.
- **Stats (`CDB_ARB_STATS_EN` defined).** Scenario 2 → `_stat_grant_cnt` = {1,1,1} and `_stat_conflict_cnt` = 2.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and the CDB result record used by the
// result-bus arbiter and its source queues.
package cpu_pkg;

  localparam int ROB_ID_W  = 5;
  localparam int DATA_W    = 32;
  localparam int CDB_SRC_W = 3;

  // Level of rst_in that resets the core.
  localparam logic RST_ACTIVE = 1'b0;

  typedef struct packed {
    logic [ROB_ID_W-1:0] rob_id;
    logic [DATA_W-1:0]   value;
  } cdb_result_t;

  localparam int CDB_RESULT_W = $bits(cdb_result_t);

endpackage

// File: rtl/cdb_arbiter_if.sv
// Result-source and CDB broadcast signals of the arbiter.
// The master side offers results and consumes the broadcast; the slave side is the arbiter.
interface cdb_arbiter_if #(
  parameter int NUM_SRC  = 3,
  parameter int ROB_ID_W = cpu_pkg::ROB_ID_W,
  parameter int DATA_W   = cpu_pkg::DATA_W
);

  logic [NUM_SRC-1:0]          _src_valid;
  logic [NUM_SRC-1:0]          _src_ready;
  logic [NUM_SRC*ROB_ID_W-1:0] _src_rob_id;
  logic [NUM_SRC*DATA_W-1:0]   _src_value;

  logic                        _cdb_ready;
  logic [ROB_ID_W-1:0]         _cdb_rob_id;
  logic [DATA_W-1:0]           _cdb_value;
  logic [2:0]                  _cdb_src;

  modport master (
    output _src_valid, _src_rob_id, _src_value,
    input  _src_ready, _cdb_ready, _cdb_rob_id, _cdb_value, _cdb_src
  );

  modport slave (
    input  _src_valid, _src_rob_id, _src_value,
    output _src_ready, _cdb_ready, _cdb_rob_id, _cdb_value, _cdb_src
  );

endinterface

// File: rtl/cdb_src_fifo.sv
// Per-source result queue: small circular FIFO with occupancy count and flush.
// Push and pop are pre-qualified by the arbiter; flush empties the queue.
module cdb_src_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = cpu_pkg::CDB_RESULT_W
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count
);

  import cpu_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_in) begin
    if (rst_in == RST_ACTIVE || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count gates every read, so stale
  // contents are never observed and the array can map onto plain flops/RAM.
  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the CDB among NUM_SRC result producers, one broadcast per cycle.
// Optional statistics counters are built when CDB_ARB_STATS_EN is defined.
module cdb_arbiter #(
  parameter int NUM_SRC  = 3,
  parameter int DEPTH    = 2,
  parameter int ROB_ID_W = cpu_pkg::ROB_ID_W,
  parameter int DATA_W   = cpu_pkg::DATA_W
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     _clear,
  cdb_arbiter_if.slave             bus
`ifdef CDB_ARB_STATS_EN
  ,
  output logic [NUM_SRC*32-1:0]    _stat_grant_cnt,
  output logic [31:0]              _stat_conflict_cnt
`endif
);

  import cpu_pkg::*;

  localparam int SRC_W = $clog2(NUM_SRC);
  localparam int ENT_W = ROB_ID_W + DATA_W;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0]   count [NUM_SRC];
  logic [ENT_W-1:0]   head  [NUM_SRC];
  logic [NUM_SRC-1:0] cand;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic [NUM_SRC-1:0] src_ready;

  logic [SRC_W-1:0]   last_grant;
  logic [SRC_W-1:0]   grant_idx;
  logic               grant_valid;
  logic               do_grant;
  logic [ENT_W-1:0]   head_sel;

  logic                cdb_ready_q;
  logic [ROB_ID_W-1:0] cdb_rob_id_q;
  logic [DATA_W-1:0]   cdb_value_q;
  logic [2:0]          cdb_src_q;

  // Ready looks only at the registered count, so no valid->ready path exists.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign cand[gi]      = (count[gi] != '0);
    assign src_ready[gi] = rdy_in && !_clear && (count[gi] != CNT_W'(DEPTH));
    assign push[gi]      = bus._src_valid[gi] && src_ready[gi];
    assign pop[gi]       = do_grant && (grant_idx == SRC_W'(gi));

    cdb_src_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENT_W)
    ) u_fifo (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .flush  (_clear),
      .push   (push[gi]),
      .pop    (pop[gi]),
      .wdata  ({bus._src_rob_id[gi*ROB_ID_W +: ROB_ID_W],
                bus._src_value[gi*DATA_W +: DATA_W]}),
      .rdata  (head[gi]),
      .count  (count[gi])
    );
  end

  assign bus._src_ready = src_ready;

  // NOTE: combinational logic uses blocking assignments and gives every output
  // a default first, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      if (!grant_valid && cand[(int'(last_grant) + k) % NUM_SRC]) begin
        grant_valid = 1'b1;
        grant_idx   = SRC_W'((int'(last_grant) + k) % NUM_SRC);
      end
    end
  end

  assign do_grant = grant_valid && rdy_in && !_clear;
  assign head_sel = head[grant_idx];

  always_ff @(posedge clk_in) begin
    if (rst_in == RST_ACTIVE) begin
      cdb_ready_q  <= 1'b0;
      cdb_rob_id_q <= '0;
      cdb_value_q  <= '0;
      cdb_src_q    <= '0;
      last_grant   <= SRC_W'(NUM_SRC - 1);
    end else if (!do_grant) begin
      // Flush, freeze and idle all drop the strobe but keep the last payload.
      cdb_ready_q <= 1'b0;
    end else begin
      cdb_ready_q  <= 1'b1;
      cdb_rob_id_q <= head_sel[ENT_W-1 -: ROB_ID_W];
      cdb_value_q  <= head_sel[DATA_W-1:0];
      cdb_src_q    <= CDB_SRC_W'(grant_idx);
      last_grant   <= grant_idx;
    end
  end

  assign bus._cdb_ready  = cdb_ready_q;
  assign bus._cdb_rob_id = cdb_rob_id_q;
  assign bus._cdb_value  = cdb_value_q;
  assign bus._cdb_src    = cdb_src_q;

`ifdef CDB_ARB_STATS_EN
  logic [31:0] grant_cnt [NUM_SRC];
  logic [31:0] conflict_cnt;

  // Counters survive flushes; only reset clears them, and freeze pauses them.
  always_ff @(posedge clk_in) begin
    if (rst_in == RST_ACTIVE) begin
      for (int i = 0; i < NUM_SRC; i++) grant_cnt[i] <= '0;
      conflict_cnt <= '0;
    end else if (rdy_in) begin
      if ($countones(cand) >= 2) conflict_cnt <= conflict_cnt + 32'd1;
      if (do_grant) grant_cnt[grant_idx] <= grant_cnt[grant_idx] + 32'd1;
    end
  end

  for (genvar gs = 0; gs < NUM_SRC; gs++) begin : g_stat
    assign _stat_grant_cnt[gs*32 +: 32] = grant_cnt[gs];
  end
  assign _stat_conflict_cnt = conflict_cnt;
`endif

endmodule
